multi_alarm_controller: RTL and testbench
=========================================

// Module: multi_alarm_controller
// PURPOSE
//   N-slot alarm engine: holds NUM_ALARMS independent BCD alarm times with per-slot enables and compares them against
//   the running time once per minute. Drives one ring/snooze/dismiss state machine.
//   Sits between the time counter and the display/alarm-output logic, replacing the single-alarm path.
// PARAMETERS
//   NUM_ALARMS       4   number of alarm slots (1..16)
//   RING_TIMEOUT_MIN 5   minute ticks a ring lasts before auto-dismiss (1..255)
//   SNOOZE_MIN       9   minute ticks spent in SNOOZED before re-ring (1..255; used only with ALARM_SNOOZE_EN)
//   IDX_W            derived: max(1,$clog2(NUM_ALARMS)), slot index width
// PORTS
//   i_Clk           in   1        system clock (5 MHz domain)
//   i_Reset         in   1        synchronous, active-high reset
//   i_Time          in   16       current time, BCD {Htens,Hones,Mtens,Mones}, 24 h, 00:00..23:59
//   i_Minute_Tick   in   1        1-cycle pulse; i_Time holds the new minute in this cycle
//   i_Sel           in   IDX_W    slot selected for edit/readback
//   i_Minutes_Inc   in   1        1-cycle pulse: selected slot minutes +1
//   i_Hours_Inc     in   1        1-cycle pulse: selected slot hours +1
//   i_Enable_Toggle in   1        1-cycle pulse: invert selected slot enable
//   i_Dismiss       in   1        1-cycle pulse: stop ringing/snooze
//   i_Snooze        in   1        1-cycle pulse: snooze current ring
//   o_Sel_Time      out  16       BCD alarm time of slot i_Sel
//   o_Enabled       out  NUM_ALARMS per-slot enable flags
//   o_Ringing       out  1        alarm sounding
//   o_Ring_Id       out  IDX_W    slot that caused current ring/snooze
//   o_Snoozed       out  1        in SNOOZED state
// BEHAVIOUR
//   Reset: all slot times 00:00, o_Enabled=0, state IDLE, o_Ringing=0, o_Snoozed=0, o_Ring_Id=0, counters 0.
//   Edits (any state): minutes BCD inc 09->10, 59->00 (no hour carry); hours 09->10, 19->20, 23->00.
//     Minute and hour pulses in the same cycle both apply. i_Sel>=NUM_ALARMS: edits ignored, o_Sel_Time=16'h0000.
//   o_Sel_Time combinational from i_Sel; edits visible the cycle after the pulse.
//   FSM IDLE / RINGING / SNOOZED; all outputs registered, state change visible 1 cycle after the causing input.
//   IDLE: on i_Minute_Tick, lowest-index enabled slot with time==i_Time -> RINGING, latch o_Ring_Id, timeout cnt=0.
//   RINGING: i_Dismiss -> IDLE. i_Snooze -> SNOOZED, snooze cnt=0.
//     Each tick increments timeout cnt; at RING_TIMEOUT_MIN -> IDLE.
//   SNOOZED: i_Dismiss -> IDLE. Each tick increments snooze cnt; at SNOOZE_MIN -> RINGING, timeout cnt=0.
//   Priority in one cycle: i_Reset > i_Dismiss > i_Snooze > tick-driven transition.
//   Matches while RINGING/SNOOZED are dropped, not queued. A tick coinciding with dismiss does not start a ring.
//   Disabling the o_Ring_Id slot while RINGING/SNOOZED acts as i_Dismiss. Editing its time has no effect on the ring.
//   Re-arm: after IDLE, the same slot rings again only on a later matching tick (next day).
// CONFIGURATION
//   ALARM_SNOOZE_EN defined: SNOOZED state, snooze counter and i_Snooze behave as above.
//   Not defined: i_Snooze ignored, SNOOZED unreachable, o_Snoozed tied 0, SNOOZE_MIN unused, no snooze counter.
// STRUCTURE
//   Package alarm_pkg: bcd_time_t (4x4-bit nibbles), alarm_state_t enum {IDLE,RINGING,SNOOZED},
//     functions bcd_min_inc / bcd_hour_inc, constant TIME_ZERO=16'h0000.
//   Sub-module alarm_slot (one per slot via generate): time reg, enable reg, edit logic, registered-free match output.
//     Ports: i_Clk, i_Reset, edit pulses gated by select, i_Time, o_Time, o_Enabled, o_Match.
//   Top: priority encoder over o_Match, FSM, timeout/snooze counters, readback mux.
// TESTING
//   1 Reset, sel=2, 7x hours_inc, 30x min_inc -> o_Sel_Time=16'h0730. Slot 0 still 0000. hours 23 +1 -> 00, min 59 +1 -> 00.
//   2 Enable slots 1,3 both 06:15. Tick with i_Time=0615 -> next cycle o_Ringing=1, o_Ring_Id=1.
//   3 Ringing, no dismiss, 5 ticks (RING_TIMEOUT_MIN=5) -> o_Ringing=0 after 5th. Dismiss+tick same cycle at match -> stays IDLE.
//   4 ALARM_SNOOZE_EN: ring, snooze -> o_Snoozed=1, o_Ringing=0. 9 ticks -> o_Ringing=1, o_Ring_Id unchanged.
//     Without macro: snooze ignored, ringing persists.
//   5 Ringing on slot 1, toggle slot 1 enable -> IDLE next cycle. Assert i_Reset mid-SNOOZED -> all outputs at reset values.
//   6 NUM_ALARMS=1 build: i_Sel=0 edits/match work. Matching tick while RINGING does not change o_Ring_Id.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and BCD increment helpers for the multi-slot alarm engine.
// Pure declarations, no latency or flow control of their own.
package alarm_pkg;

    typedef struct packed {
        logic [3:0] h_tens;
        logic [3:0] h_ones;
        logic [3:0] m_tens;
        logic [3:0] m_ones;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    localparam logic [15:0] TIME_ZERO = 16'h0000;

    // Minutes wrap 59 -> 00 with no carry into the hours field.
    function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] == 4'd9) begin
            r = (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_hour_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23) begin
            r = 8'h00;
        end else if (h[3:0] == 4'd9) begin
            r = {h[7:4] + 4'd1, 4'd0};
        end else begin
            r = {h[7:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: BCD time and enable registers, edits land 1 cycle after the pulse.
// No backpressure; o_Match is combinational from registered state and i_Time.
module alarm_slot
    import alarm_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Minutes_Inc,
    input  logic        i_Hours_Inc,
    input  logic        i_Enable_Toggle,
    input  logic [15:0] i_Time,
    output logic [15:0] o_Time,
    output logic        o_Enabled,
    output logic        o_Match
);

    bcd_time_t alarm_time;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            alarm_time <= TIME_ZERO;
            o_Enabled  <= 1'b0;
        end else begin
            if (i_Minutes_Inc) begin
                {alarm_time.m_tens, alarm_time.m_ones} <=
                    bcd_min_inc({alarm_time.m_tens, alarm_time.m_ones});
            end
            if (i_Hours_Inc) begin
                {alarm_time.h_tens, alarm_time.h_ones} <=
                    bcd_hour_inc({alarm_time.h_tens, alarm_time.h_ones});
            end
            if (i_Enable_Toggle) begin
                o_Enabled <= ~o_Enabled;
            end
        end
    end

    assign o_Time  = alarm_time;
    assign o_Match = o_Enabled && (alarm_time == i_Time);

endmodule

// File: rtl/multi_alarm_controller.sv
// N-slot alarm engine with ring/snooze/dismiss FSM; outputs registered, 1 cycle after the cause.
// No backpressure; snooze support built only when ALARM_SNOOZE_EN is defined.
module multi_alarm_controller
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS       = 4,
    parameter int RING_TIMEOUT_MIN = 5,
    parameter int SNOOZE_MIN       = 9,
    parameter int IDX_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [15:0]           i_Time,
    input  logic                  i_Minute_Tick,
    input  logic [IDX_W-1:0]      i_Sel,
    input  logic                  i_Minutes_Inc,
    input  logic                  i_Hours_Inc,
    input  logic                  i_Enable_Toggle,
    input  logic                  i_Dismiss,
    input  logic                  i_Snooze,
    output logic [15:0]           o_Sel_Time,
    output logic [NUM_ALARMS-1:0] o_Enabled,
    output logic                  o_Ringing,
    output logic [IDX_W-1:0]      o_Ring_Id,
    output logic                  o_Snoozed
);

    logic [NUM_ALARMS-1:0] sel_hit;
    logic [NUM_ALARMS-1:0] match;
    logic [15:0]           slot_time [NUM_ALARMS];

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
        // An out-of-range i_Sel hits no slot, so its edits fall away.
        assign sel_hit[g] = (i_Sel == IDX_W'(g));

        alarm_slot u_slot (
            .i_Clk           (i_Clk),
            .i_Reset         (i_Reset),
            .i_Minutes_Inc   (i_Minutes_Inc & sel_hit[g]),
            .i_Hours_Inc     (i_Hours_Inc & sel_hit[g]),
            .i_Enable_Toggle (i_Enable_Toggle & sel_hit[g]),
            .i_Time          (i_Time),
            .o_Time          (slot_time[g]),
            .o_Enabled       (o_Enabled[g]),
            .o_Match         (match[g])
        );
    end

    always_comb begin
        o_Sel_Time = TIME_ZERO;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_hit[i]) o_Sel_Time = slot_time[i];
        end
    end

    logic             any_match;
    logic [IDX_W-1:0] match_id;

    always_comb begin
        any_match = 1'b0;
        match_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                match_id  = IDX_W'(i);
            end
        end
    end

    // Turning off the slot that is ringing counts as a dismiss.
    logic ring_off;
    logic stop;
    assign ring_off = i_Enable_Toggle && (i_Sel == o_Ring_Id) && |(sel_hit & o_Enabled);
    assign stop     = i_Dismiss || ring_off;

    alarm_state_t     state_q, state_d;
    logic [IDX_W-1:0] ring_id_d;
    logic [7:0]       timeout_cnt, timeout_d;

`ifdef ALARM_SNOOZE_EN
    logic [7:0] snooze_cnt, snooze_d;
`else
    logic unused_snooze;
    assign unused_snooze = i_Snooze ^ SNOOZE_MIN[0];
`endif

    always_comb begin
        state_d   = state_q;
        ring_id_d = o_Ring_Id;
        timeout_d = timeout_cnt;
`ifdef ALARM_SNOOZE_EN
        snooze_d  = snooze_cnt;
`endif
        case (state_q)
            IDLE: begin
                if (i_Minute_Tick && any_match && !i_Dismiss) begin
                    state_d   = RINGING;
                    ring_id_d = match_id;
                    timeout_d = '0;
                end
            end
            RINGING: begin
                if (stop) begin
                    state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (i_Snooze) begin
                    state_d  = SNOOZED;
                    snooze_d = '0;
`endif
                end else if (i_Minute_Tick) begin
                    timeout_d = timeout_cnt + 8'd1;
                    if (timeout_cnt + 8'd1 == 8'(RING_TIMEOUT_MIN)) state_d = IDLE;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (i_Minute_Tick) begin
                    snooze_d = snooze_cnt + 8'd1;
                    if (snooze_cnt + 8'd1 == 8'(SNOOZE_MIN)) begin
                        state_d   = RINGING;
                        timeout_d = '0;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            o_Ring_Id   <= '0;
            timeout_cnt <= '0;
            o_Ringing   <= 1'b0;
            o_Snoozed   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            o_Ring_Id   <= ring_id_d;
            timeout_cnt <= timeout_d;
            o_Ringing   <= (state_d == RINGING);
            o_Snoozed   <= (state_d == SNOOZED);
`ifdef ALARM_SNOOZE_EN
            snooze_cnt  <= snooze_d;
`endif
        end
    end

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Directed bench for multi_alarm_controller with a minute/hour-level reference model.
module tb_multi_alarm_controller;

    localparam int N   = 4;
    localparam int RTO = 5;
    localparam int SNZ = 9;
    localparam int IW  = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   tm;
    logic          tick, minc, hinc, tog, dis, snz;
    logic [IW-1:0] sel;
    logic [15:0]   sel_time;
    logic [N-1:0]  enabled;
    logic          ringing, snoozed;
    logic [IW-1:0] ring_id;

    always #5 clk = ~clk;

    multi_alarm_controller #(
        .NUM_ALARMS       (N),
        .RING_TIMEOUT_MIN (RTO),
        .SNOOZE_MIN       (SNZ)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_Time          (tm),
        .i_Minute_Tick   (tick),
        .i_Sel           (sel),
        .i_Minutes_Inc   (minc),
        .i_Hours_Inc     (hinc),
        .i_Enable_Toggle (tog),
        .i_Dismiss       (dis),
        .i_Snooze        (snz),
        .o_Sel_Time      (sel_time),
        .o_Enabled       (enabled),
        .o_Ringing       (ringing),
        .o_Ring_Id       (ring_id),
        .o_Snoozed       (snoozed)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain decimal hours/minutes, state 0=idle 1=ringing 2=snoozed.
    int mh [N];
    int mm [N];
    bit men[N];
    int mst, mid, mtc, msc;
    bit mvalid = 1'b0;

    function automatic int bcd2dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] enc(input int h, input int m);
        logic [3:0] a, b, c, d;
        a = 4'(h / 10);
        b = 4'(h % 10);
        c = 4'(m / 10);
        d = 4'(m % 10);
        return {a, b, c, d};
    endfunction

    task automatic model_step();
        int hit;
        bit stop;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mh[i] = 0; mm[i] = 0; men[i] = 1'b0;
            end
            mst = 0; mid = 0; mtc = 0; msc = 0;
            mvalid = 1'b1;
        end else begin
            hit = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (men[i] && mh[i] == bcd2dec(tm[15:8]) && mm[i] == bcd2dec(tm[7:0])) hit = i;
            end
            stop = dis || (mst != 0 && tog && int'(sel) == mid && men[mid]);
            case (mst)
                0: if (tick && hit >= 0 && !dis) begin mst = 1; mid = hit; mtc = 0; end
                1: begin
                    if (stop) mst = 0;
                    else if (SNZ_EN && snz) begin mst = 2; msc = 0; end
                    else if (tick) begin
                        mtc++;
                        if (mtc == RTO) mst = 0;
                    end
                end
                default: begin
                    if (stop) mst = 0;
                    else if (tick) begin
                        msc++;
                        if (msc == SNZ) begin mst = 1; mtc = 0; end
                    end
                end
            endcase
            if (int'(sel) < N) begin
                if (minc) mm[sel] = (mm[sel] + 1) % 60;
                if (hinc) mh[sel] = (mh[sel] + 1) % 24;
                if (tog)  men[sel] = !men[sel];
            end
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] ev;
        logic [15:0]  es;
        if (mvalid) begin
            for (int i = 0; i < N; i++) ev[i] = men[i];
            es = (int'(sel) < N) ? enc(mh[sel], mm[sel]) : 16'h0000;
            chk("m_sel_time", 32'(sel_time), 32'(es));
            chk("m_enabled",  32'(enabled),  32'(ev));
            chk("m_ringing",  32'(ringing),  32'(mst == 1));
            chk("m_snoozed",  32'(snoozed),  32'(mst == 2));
            chk("m_ring_id",  32'(ring_id),  32'(mid));
        end
    end

    task automatic go();
        @(posedge clk);
        model_step();
        #2;
        tick = 0; minc = 0; hinc = 0; tog = 0; dis = 0; snz = 0;
    endtask

    logic [15:0] tt[5] = '{16'h0616, 16'h0617, 16'h0618, 16'h0619, 16'h0620};

    initial begin
        rst = 1; tm = 16'h0000; sel = '0;
        tick = 0; minc = 0; hinc = 0; tog = 0; dis = 0; snz = 0;
        go(); go();
        rst = 0;
        go();
        chk("rst_ringing",  32'(ringing),  32'd0);
        chk("rst_snoozed",  32'(snoozed),  32'd0);
        chk("rst_ring_id",  32'(ring_id),  32'd0);
        chk("rst_enabled",  32'(enabled),  32'd0);
        chk("rst_sel_time", 32'(sel_time), 32'h0000);

        // Editing and BCD wrap
        sel = 2;
        repeat (7)  begin hinc = 1; go(); end
        repeat (30) begin minc = 1; go(); end
        chk("t1_0730", 32'(sel_time), 32'h0730);
        sel = 0; #1;
        chk("t1_slot0", 32'(sel_time), 32'h0000);
        sel = 3;
        repeat (23) begin hinc = 1; go(); end
        chk("t1_h23", 32'(sel_time), 32'h2300);
        hinc = 1; go();
        chk("t1_h_wrap", 32'(sel_time), 32'h0000);
        repeat (59) begin minc = 1; go(); end
        chk("t1_m59", 32'(sel_time), 32'h0059);
        minc = 1; go();
        chk("t1_m_wrap", 32'(sel_time), 32'h0000);
        hinc = 1; minc = 1; go();
        chk("t1_both", 32'(sel_time), 32'h0101);

        // Slots 1 and 3 to 06:15, enabled; lowest index wins
        repeat (5)  begin hinc = 1; go(); end
        repeat (14) begin minc = 1; go(); end
        chk("t2_slot3", 32'(sel_time), 32'h0615);
        sel = 1;
        repeat (6)  begin hinc = 1; go(); end
        repeat (15) begin minc = 1; go(); end
        tog = 1; go();
        sel = 3; tog = 1; go();
        chk("t2_enabled", 32'(enabled), 32'b1010);
        tm = 16'h0615; tick = 1; go();
        chk("t2_ringing", 32'(ringing), 32'd1);
        chk("t2_ring_id", 32'(ring_id), 32'd1);

        // Auto timeout after RTO ticks
        for (int k = 0; k < 5; k++) begin
            tm = tt[k]; tick = 1; go();
            if (k == 3) chk("t3_still_ringing", 32'(ringing), 32'd1);
        end
        chk("t3_timeout", 32'(ringing), 32'd0);
        tm = 16'h0615; dis = 1; tick = 1; go();
        chk("t3_dis_tick", 32'(ringing), 32'd0);
        tick = 1; go();
        chk("t3_rearm", 32'(ringing), 32'd1);
        tick = 1; go();
        chk("t3_match_while_ring", 32'(ring_id), 32'd1);
        sel = 3; tog = 1; go();
        chk("t3_other_toggle", 32'(ringing), 32'd1);
        tog = 1; go();

        // Snooze
        tm = 16'h0700;
        snz = 1; go();
`ifdef ALARM_SNOOZE_EN
        chk("t4_snoozed", 32'(snoozed), 32'd1);
        chk("t4_not_ringing", 32'(ringing), 32'd0);
        repeat (8) begin tick = 1; go(); end
        chk("t4_still_snoozed", 32'(snoozed), 32'd1);
        tick = 1; go();
        chk("t4_rering", 32'(ringing), 32'd1);
        chk("t4_rering_id", 32'(ring_id), 32'd1);
`else
        chk("t4_snz_ignored", 32'(ringing), 32'd1);
        chk("t4_no_snoozed", 32'(snoozed), 32'd0);
`endif

        // Disabling the ringing slot dismisses
        sel = 1; tog = 1; go();
        chk("t5_toggle_dismiss", 32'(ringing), 32'd0);
        chk("t5_enabled", 32'(enabled), 32'b1000);
        tog = 1; go();
        tm = 16'h0615; tick = 1; go();
        chk("t5_ring_again", 32'(ringing), 32'd1);
`ifdef ALARM_SNOOZE_EN
        snz = 1; go();
`endif
        rst = 1; go();
        rst = 0;
        chk("t5_rst_ringing", 32'(ringing),  32'd0);
        chk("t5_rst_snoozed", 32'(snoozed),  32'd0);
        chk("t5_rst_id",      32'(ring_id),  32'd0);
        chk("t5_rst_en",      32'(enabled),  32'd0);
        chk("t5_rst_time",    32'(sel_time), 32'h0000);
        go();

        // Slots 2 and 3 both at 00:00: slot 2 wins
        sel = 2; tog = 1; go();
        sel = 3; tog = 1; go();
        tm = 16'h0000; tick = 1; go();
        chk("t6_prio_id", 32'(ring_id), 32'd2);
        dis = 1; go();
        chk("t6_dismiss", 32'(ringing), 32'd0);
        go();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
